// File: rtl/proc_pkg.sv
// Shared constants, requester indices and FSM encoding for the register-file
// write arbiter. Also provides the destination decoder.
package proc_pkg;

  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int NREG     = 16;
  localparam int AW       = 4;
  localparam int MAX_LOCK = 8;

  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_DS   = 2;
  localparam int REQ_CTL  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  // Addresses beyond the register bank decode to no enable at all.
  function automatic logic [NREG-1:0] onehot_dst(input logic [AW-1:0] dst);
    logic [NREG-1:0] oh;
    oh = '0;
    if (int'(dst) < NREG) oh[dst] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus3_write_arbiter_if.sv
// Requester-side write/clear and swap signals plus the register-bank strobes
// driven back by the arbiter.
interface bus3_write_arbiter_if #(
  parameter int NREQ = proc_pkg::NREQ,
  parameter int NREG = proc_pkg::NREG,
  parameter int DW   = proc_pkg::DW,
  parameter int AW   = proc_pkg::AW
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_clr;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_dst;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      bus3;
  logic [NREG-1:0]    reg_enY;
  logic               reg_wr;
  logic               reg_clr;
  logic               swp_req;
  logic [AW-1:0]      swp_dst;
  logic [1:0]         swp_data;
  logic               swp_ack;
  logic [NREG-1:0]    reg_enS;
  logic               swp2;
  logic [1:0]         bus5;
  logic               busy;

  modport master (
    output req, req_clr, req_lock, req_dst, req_data,
    output swp_req, swp_dst, swp_data,
    input  gnt, bus3, reg_enY, reg_wr, reg_clr,
    input  swp_ack, reg_enS, swp2, bus5, busy
  );

  modport slave (
    input  req, req_clr, req_lock, req_dst, req_data,
    input  swp_req, swp_dst, swp_data,
    output gnt, bus3, reg_enY, reg_wr, reg_clr,
    output swp_ack, reg_enS, swp2, bus5, busy
  );

endinterface

// File: rtl/bus3_write_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or above the
// pointer, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW:0] w_pos;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    // Walk offsets from far to near so the nearest hit is the last written.
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = {1'b0, i_ptr} + (IW + 1)'(k);
      if (w_pos >= (IW + 1)'(N)) w_pos = w_pos - (IW + 1)'(N);
      if (i_req[w_pos[IW-1:0]]) begin
        o_idx   = w_pos[IW-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus3_write_arbiter.sv
// Round-robin arbiter for the register-file write bus (bus3) with optional
// locked bursts, plus the independent 2-bit swap path (bus5).
module bus3_write_arbiter
  import proc_pkg::*;
#(
  parameter int NREQ     = proc_pkg::NREQ,
  parameter int NREG     = proc_pkg::NREG,
  parameter int DW       = proc_pkg::DW,
  parameter int AW       = proc_pkg::AW,
  parameter int MAX_LOCK = proc_pkg::MAX_LOCK
) (
  input logic                 clk,
  input logic                 rst,
  bus3_write_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_LOCK + 1);

  state_e          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;

  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_valid;
  logic [IW-1:0]   w_win;
  logic            w_win_valid;
  logic [NREQ-1:0] w_gnt;
  logic [AW-1:0]   w_dst;
  logic [DW-1:0]   w_data;
  logic            w_clr;
  logic            w_lock;
  logic [NREG-1:0] w_enY;
  logic            w_conflict;

  rr_pick #(.N(NREQ)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // While a burst owns the bus only the owner is eligible.
  always_comb begin
    w_win       = w_pick_idx;
    w_win_valid = w_pick_valid;
    if (r_state == OWNED) begin
      w_win       = r_owner;
      w_win_valid = bus.req[r_owner];
    end
    w_gnt  = '0;
    w_dst  = '0;
    w_data = '0;
    w_clr  = 1'b0;
    w_lock = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (IW'(k) == w_win) begin
        w_gnt[k] = w_win_valid;
        w_dst    = bus.req_dst[k*AW +: AW];
        w_data   = bus.req_data[k*DW +: DW];
        w_clr    = bus.req_clr[k];
        w_lock   = bus.req_lock[k];
      end
    end
  end

  assign w_enY      = onehot_dst(w_dst);
  assign w_conflict = w_win_valid && (w_dst == bus.swp_dst);

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      bus.gnt     <= '0;
      bus.bus3    <= '0;
      bus.reg_enY <= '0;
      bus.reg_wr  <= 1'b0;
      bus.reg_clr <= 1'b0;
      bus.swp_ack <= 1'b0;
      bus.reg_enS <= '0;
      bus.swp2    <= 1'b0;
      bus.bus5    <= '0;
      bus.busy    <= 1'b0;
    end else begin
      bus.gnt     <= w_gnt;
      bus.reg_enY <= '0;
      bus.reg_wr  <= 1'b0;
      bus.reg_clr <= 1'b0;
      bus.swp_ack <= 1'b0;
      bus.reg_enS <= '0;
      bus.swp2    <= 1'b0;

      if (w_win_valid) begin
        bus.bus3    <= w_data;
        bus.reg_enY <= w_enY;
        bus.reg_wr  <= ~w_clr;
        bus.reg_clr <= w_clr;
      end

      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_ptr <= (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
            if (w_lock) begin
              r_state  <= OWNED;
              r_owner  <= w_pick_idx;
              r_cnt    <= CW'(1);
              bus.busy <= 1'b1;
            end
          end
        end
        OWNED: begin
          if (!w_win_valid) begin
            r_state  <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            // This grant is the last one when lock drops or the cap is reached.
            if (!w_lock || r_cnt >= CW'(MAX_LOCK - 1)) begin
              r_state  <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase

      // A write to the same register wins; the swap waits for a free cycle.
      if (bus.swp_req && !w_conflict) begin
        bus.swp_ack <= 1'b1;
        bus.swp2    <= 1'b1;
        bus.reg_enS <= onehot_dst(bus.swp_dst);
        bus.bus5    <= bus.swp_data;
      end
    end
  end

endmodule

// File: tb/tb_bus3_write_arbiter.sv
// Self-checking bench for bus3_write_arbiter: directed scenarios followed by
// randomized traffic, all outputs compared against a behavioural model.
module tb_bus3_write_arbiter;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus3_write_arbiter_if bus ();

  bus3_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner < 0 means nobody holds a lock.
  int m_ptr   = 0;
  int m_owner = -1;
  int m_cnt   = 0;

  logic [NREQ-1:0] e_gnt;
  logic [DW-1:0]   e_bus3;
  logic [NREG-1:0] e_enY;
  logic [NREG-1:0] e_enS;
  logic            e_wr, e_clr, e_ack, e_swp2, e_busy;
  logic [1:0]      e_bus5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predict what the next rising edge should produce from current inputs.
  task automatic model_step();
    int win;
    int c;
    logic [AW-1:0] dst;
    e_gnt  = '0;
    e_enY  = '0;
    e_enS  = '0;
    e_wr   = 1'b0;
    e_clr  = 1'b0;
    e_ack  = 1'b0;
    e_swp2 = 1'b0;
    if (!rst) begin
      m_ptr   = 0;
      m_owner = -1;
      m_cnt   = 0;
      e_bus3  = '0;
      e_bus5  = '0;
      e_busy  = 1'b0;
      return;
    end
    win = -1;
    if (m_owner >= 0) begin
      if (bus.req[m_owner]) begin
        win = m_owner;
        m_cnt++;
        if (!bus.req_lock[m_owner] || m_cnt >= MAX_LOCK) m_owner = -1;
      end else begin
        m_owner = -1;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (win < 0 && bus.req[c]) win = c;
      end
      if (win >= 0) begin
        m_ptr = (win + 1) % NREQ;
        if (bus.req_lock[win]) begin
          m_owner = win;
          m_cnt   = 1;
        end
      end
    end
    dst = '0;
    if (win >= 0) begin
      dst        = bus.req_dst[win*AW +: AW];
      e_gnt[win] = 1'b1;
      e_bus3     = bus.req_data[win*DW +: DW];
      if (int'(dst) < NREG) e_enY[dst] = 1'b1;
      e_clr      = bus.req_clr[win];
      e_wr       = ~bus.req_clr[win];
    end
    e_busy = (m_owner >= 0);
    if (bus.swp_req && !(win >= 0 && dst == bus.swp_dst)) begin
      e_ack  = 1'b1;
      e_swp2 = 1'b1;
      e_bus5 = bus.swp_data;
      if (int'(bus.swp_dst) < NREG) e_enS[bus.swp_dst] = 1'b1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("gnt",     32'(bus.gnt),     32'(e_gnt));
    check("bus3",    32'(bus.bus3),    32'(e_bus3));
    check("reg_enY", 32'(bus.reg_enY), 32'(e_enY));
    check("reg_wr",  32'(bus.reg_wr),  32'(e_wr));
    check("reg_clr", 32'(bus.reg_clr), 32'(e_clr));
    check("swp_ack", 32'(bus.swp_ack), 32'(e_ack));
    check("reg_enS", 32'(bus.reg_enS), 32'(e_enS));
    check("swp2",    32'(bus.swp2),    32'(e_swp2));
    check("bus5",    32'(bus.bus5),    32'(e_bus5));
    check("busy",    32'(bus.busy),    32'(e_busy));
  endtask

  task automatic clear_inputs();
    bus.req      = '0;
    bus.req_clr  = '0;
    bus.req_lock = '0;
    bus.req_dst  = '0;
    bus.req_data = '0;
    bus.swp_req  = 1'b0;
    bus.swp_dst  = '0;
    bus.swp_data = '0;
  endtask

  logic [DW-1:0] data_tbl [NREQ] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    clear_inputs();
    rst = 1'b0;
    cycle();
    cycle();
    check("rst_gnt",  32'(bus.gnt),    32'h0);
    check("rst_busy", 32'(bus.busy),   32'h0);
    check("rst_bus3", 32'(bus.bus3),   32'h0);

    // All four requesters at once from reset: served 0,1,2,3.
    rst = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_dst[i*AW +: AW]  = AW'(i + 1);
      bus.req_data[i*DW +: DW] = data_tbl[i];
    end
    for (int i = 0; i < NREQ; i++) begin
      cycle();
      check("rr_gnt",  32'(bus.gnt),     32'(1) << i);
      check("rr_bus3", 32'(bus.bus3),    32'(data_tbl[i]));
      check("rr_enY",  32'(bus.reg_enY), 32'(1) << (i + 1));
      bus.req[i] = 1'b0;
    end

    // Clear request lasts exactly one cycle.
    clear_inputs();
    bus.req[2]            = 1'b1;
    bus.req_clr[2]        = 1'b1;
    bus.req_dst[2*AW +: AW] = 4'd5;
    cycle();
    check("clr_clr", 32'(bus.reg_clr), 32'h1);
    check("clr_wr",  32'(bus.reg_wr),  32'h0);
    check("clr_enY", 32'(bus.reg_enY), 32'h0020);
    clear_inputs();
    cycle();
    check("clr_once", 32'(bus.reg_clr), 32'h0);
    check("clr_enY0", 32'(bus.reg_enY), 32'h0);

    // Locked burst by requester 1 is capped, then requester 0 gets in.
    bus.req[1]      = 1'b1;
    bus.req_lock[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (c <= 7) begin
        check("lock_gnt",  32'(bus.gnt),  32'h2);
        check("lock_busy", 32'(bus.busy), (c < 7) ? 32'h1 : 32'h0);
      end else if (c == 8) begin
        check("after_lock_gnt", 32'(bus.gnt), 32'h1);
        bus.req[0] = 1'b0;
      end
      if (c == 0) bus.req[0] = 1'b1;
    end
    clear_inputs();
    cycle();
    check("lock_release_busy", 32'(bus.busy), 32'h0);

    // Swap to the register being written is deferred by one cycle.
    bus.req[0]               = 1'b1;
    bus.req_dst[0*AW +: AW]  = 4'd3;
    bus.req_data[0*DW +: DW] = 8'h5A;
    bus.swp_req              = 1'b1;
    bus.swp_dst              = 4'd3;
    bus.swp_data             = 2'b10;
    cycle();
    check("conf_gnt", 32'(bus.gnt),     32'h1);
    check("conf_wr",  32'(bus.reg_wr),  32'h1);
    check("conf_ack", 32'(bus.swp_ack), 32'h0);
    check("conf_swp", 32'(bus.swp2),    32'h0);
    bus.req[0] = 1'b0;
    cycle();
    check("defer_swp2", 32'(bus.swp2),    32'h1);
    check("defer_enS",  32'(bus.reg_enS), 32'h0008);
    check("defer_bus5", 32'(bus.bus5),    32'h2);
    clear_inputs();

    // Different destinations proceed together.
    bus.req[3]               = 1'b1;
    bus.req_dst[3*AW +: AW]  = 4'd3;
    bus.req_data[3*DW +: DW] = 8'h77;
    bus.swp_req              = 1'b1;
    bus.swp_dst              = 4'd7;
    bus.swp_data             = 2'b01;
    cycle();
    check("both_gnt",  32'(bus.gnt),     32'h8);
    check("both_enY",  32'(bus.reg_enY), 32'h0008);
    check("both_swp2", 32'(bus.swp2),    32'h1);
    check("both_enS",  32'(bus.reg_enS), 32'h0080);
    check("both_bus5", 32'(bus.bus5),    32'h1);
    clear_inputs();

    // Reset in the middle of a burst.
    bus.req[2]              = 1'b1;
    bus.req_lock[2]         = 1'b1;
    bus.req_dst[2*AW +: AW] = 4'd9;
    cycle();
    cycle();
    check("burst_busy", 32'(bus.busy), 32'h1);
    rst = 1'b0;
    cycle();
    check("mid_rst_busy", 32'(bus.busy),   32'h0);
    check("mid_rst_gnt",  32'(bus.gnt),    32'h0);
    check("mid_rst_wr",   32'(bus.reg_wr), 32'h0);
    rst = 1'b1;
    bus.req      = 4'b1111;
    bus.req_lock = '0;
    cycle();
    check("restart_gnt", 32'(bus.gnt), 32'h1);
    clear_inputs();
    cycle();

    // Randomized traffic: requests tend to persist so bursts reach the cap.
    for (int t = 0; t < 600; t++) begin
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(3) == 0) begin
          bus.req[r]              = 1'($urandom_range(1));
          bus.req_lock[r]         = ($urandom_range(2) == 0);
          bus.req_clr[r]          = ($urandom_range(3) == 0);
          bus.req_dst[r*AW +: AW] = AW'($urandom);
        end
        bus.req_data[r*DW +: DW] = DW'($urandom);
      end
      bus.swp_req  = 1'($urandom_range(1));
      bus.swp_dst  = ($urandom_range(1) == 1) ? bus.req_dst[$urandom_range(NREQ - 1)*AW +: AW]
                                              : AW'($urandom);
      bus.swp_data = 2'($urandom);
      rst          = ($urandom_range(60) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus3_write_arbiter.md
Name: bus3_write_arbiter

Overview:
- Shares the 8-bit write bus (bus3) and the 2-bit swap path (bus5) of the register file among NREQ datapath requesters (ALU, memory loader, down-sampler, control).
- Grants one write or clear per cycle, round-robin, with an optional locked burst.
- Drives each register's enY/wr/clr strobes and enS/swp2 strobes.
- Sits between the control unit and the bank of 8-bit data registers.

Parameters:
- NREQ, 4, number of write requesters.
- NREG, 16, number of destination registers.
- DW, 8, data width of bus3.
- AW, 4, register address width (clog2 NREG).
- MAX_LOCK, 8, maximum consecutive cycles one locked owner may hold the bus.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  NREQ  write/clear request per requester; held until granted.
- req_clr  in  NREQ  1 = clear request, 0 = data write.
- req_lock  in  NREQ  keep ownership after this grant (burst).
- req_dst  in  NREQ*AW  destination register per requester.
- req_data  in  NREQ*DW  write data per requester.
- gnt  out  NREQ  one-hot, 1-cycle grant pulse.
- bus3  out  DW  muxed write data.
- reg_enY  out  NREG  one-hot destination enable.
- reg_wr  out  1  write strobe.
- reg_clr  out  1  clear strobe.
- swp_req  in  1  swap-path request.
- swp_dst  in  AW  swap target register.
- swp_data  in  2  low-bit swap value.
- swp_ack  out  1  1-cycle acknowledge of the swap.
- reg_enS  out  NREG  one-hot swap enable.
- swp2  out  1  swap strobe.
- bus5  out  2  swap data.
- busy  out  1  high while a locked owner holds the bus.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a rising edge):
  - gnt, reg_enY, reg_wr, reg_clr, swp_ack, reg_enS, swp2, busy = 0; bus3 = 0; bus5 = 0.
  - Round-robin pointer = 0; state = IDLE; lock counter = 0.
  - A reset mid-burst drops ownership immediately; no strobe is issued on the reset edge.
- State machine has two states, IDLE and OWNED.
- IDLE:
  - Pick the first requester with req=1, searching from the pointer upward and wrapping modulo NREQ.
  - Next edge: gnt[i]=1, bus3=req_data[i], reg_enY=onehot(req_dst[i]).
  - reg_wr = ~req_clr[i]; reg_clr = req_clr[i]. reg_wr and reg_clr are never both 1.
  - Pointer becomes i+1 (wraps to 0 from NREQ-1).
  - If req_lock[i]=1: go to OWNED, owner=i, lock counter=1, busy=1.
- OWNED:
  - Only the owner is granted; one write per cycle while req[owner]=1.
  - Counter increments on each grant.
  - Return to IDLE (busy=0) on the first of:
    - req_lock[owner]=0 on a granted cycle (that grant is the last);
    - req[owner]=0 (no strobe that cycle);
    - counter reaching MAX_LOCK.
  - Other requesters wait. The pointer does not move during OWNED.
- Latency: req sampled at edge N gives gnt and strobes at edge N+1.
  - Requester drops req in the cycle after it sees gnt, unless it is bursting.
  - A requester that never drops req is re-arbitrated; round-robin guarantees no starvation beyond NREQ-1 grants, plus MAX_LOCK-1 cycles during a lock.
- No request pending: all strobes 0; bus3 holds its last value.
- req_dst >= NREG: grant is issued, reg_enY=0, and no register changes.
- Swap path:
  - Runs in the same cycle as writes.
  - On swp_req: swp_ack=1, reg_enS=onehot(swp_dst), swp2=1, bus5=swp_data.
  - Conflict rule: if the same cycle grants a write or clear with req_dst==swp_dst, the write proceeds and the swap is deferred. swp_ack=0 and swp2=0 that cycle; swp_req must be held.
  - Different destinations: both are issued in the same cycle.
  - The swap path never stalls a write.
- All strobes (gnt, reg_wr, reg_clr, swp2, swp_ack) are single-cycle pulses per accepted transaction.

Decomposition:
- Shared package (proc_pkg):
  - constants DW=8, NREG=16, AW=4;
  - requester index constants REQ_ALU=0, REQ_MEM=1, REQ_DS=2, REQ_CTL=3;
  - FSM state encoding IDLE=0, OWNED=1.
- One natural sub-module: rr_pick, a combinational round-robin first-set finder (req vector, pointer, outputs index and valid).
- Decoders and muxes stay inline.

Test Plan:
- Simultaneous requests: req=4'b1111 with dst 1,2,3,4 and data 8'h11,22,33,44 from reset -> gnt order 0,1,2,3 on four consecutive cycles; bus3 = 11,22,33,44; reg_enY = bit 1,2,3,4.
- Clear request: req[2]=1, req_clr[2]=1, dst=5 -> reg_clr=1, reg_wr=0, reg_enY=16'h0020 for exactly one cycle.
- Burst lock: req[1] with req_lock held for 10 cycles, req[0] also pending -> owner 1 granted 8 consecutive cycles (MAX_LOCK); busy drops; the next grant goes to 0.
- Swap conflict: write to dst 3 and swp_req to dst 3 in the same cycle -> write issued, swp_ack=0. Next cycle: swp2=1, reg_enS=16'h0008, bus5=swp_data.
- Swap with a different destination: write to dst 3 and swap to dst 7 together -> both strobes in the same cycle.
- Reset mid-burst: rst=0 during OWNED -> next edge all outputs 0, busy=0. After release, arbitration restarts from requester 0.
